decimal_to_bcd_keypad: RTL

- Sequential decimal-to-BCD encoder for ten decimal key lines x0..x9; the inverse of the BCD-to-decimal decoder path.
- Synchronizes the lines, debounces them, and priority-encodes the highest pressed digit to BCD a,b,c,d (a = MSB).
- Presents exactly one code per key press on a valid/ready handshake.
- Sits between raw panel switches and downstream BCD consumers (display, arithmetic).

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/decimal_to_bcd_keypad.sv | 127 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the decimal key panel encoder.
// State encoding plus the priority-encode and multi-key functions.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Highest set bit wins; an all-zero vector maps to 0 and is told apart by valid.
    function automatic logic [3:0] dec_to_bcd(input logic [9:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) code = 4'(i);
        end
        return code;
    endfunction

    function automatic logic multi_hot(input logic [9:0] v);
        return $countones(v) > 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous panel inputs.
// Resets both stages to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/decimal_to_bcd_keypad.sv
// Debounced decimal-key to BCD encoder; one code per press on a valid/ready handshake.
// Held or bouncing keys after a report are ignored until a clean release.
module decimal_to_bcd_keypad
    import keypad_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic x5,
    input  logic x6,
    input  logic x7,
    input  logic x8,
    input  logic x9,
    input  logic ready,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic valid,
    output logic multi
);

    localparam logic [DB_W-1:0] CntLast = DB_W'(DB_CYCLES - 1);

    logic [9:0] s;
    state_t     state_q, state_d;
    logic [9:0] cand_q, cand_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       multi_q, multi_d;
    logic       valid_q, valid_d;

    sync_2ff #(
        .WIDTH(10)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  ({x9, x8, x7, x6, x5, x4, x3, x2, x1, x0}),
        .q  (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        multi_d = multi_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (s != '0) begin
                    cand_d  = s;
                    cnt_d   = DB_W'(1);
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s == cand_q && cnt_q == CntLast) begin
                    code_d  = dec_to_bcd(cand_q);
                    multi_d = multi_hot(cand_q);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (s == cand_q) begin
                    cnt_d = cnt_q + DB_W'(1);
                end else if (s == '0) begin
                    state_d = IDLE;
                end else begin
                    // Key set changed mid-count: restart on the new pattern.
                    cand_d = s;
                    cnt_d  = DB_W'(1);
                end
            end
            HOLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (s == '0) begin
                    if (cnt_q == CntLast) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a     = code_q[3];
    assign b     = code_q[2];
    assign c     = code_q[1];
    assign d     = code_q[0];
    assign valid = valid_q;
    assign multi = multi_q;

endmodule
